// File: rtl/rv_pkg.sv
// Shared register-file writeback types: data width, register index width and
// the pending-write entry held by the writeback queue.
package rv_pkg;

   localparam int XLEN      = 64;
   localparam int REG_IDX_W = 5;

   // One pending register-file write: destination index plus result value.
   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Bypass lookup over the pending-write FIFO.
// Reports whether any held entry targets i_idx. If one does, it returns the
// value from the youngest such entry. Register x0 never matches.
module wb_bypass_match
   import rv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNTW  = $clog2(DEPTH + 1)
) (
   input  wb_entry_t [DEPTH-1:0]        i_entries,
   input  logic [$clog2(DEPTH)-1:0]     i_head,
   input  logic [CNTW-1:0]              i_count,
   input  logic [REG_IDX_W-1:0]         i_idx,
   output logic                         o_hit,
   output logic [XLEN-1:0]              o_data
);

   localparam int PTRW = $clog2(DEPTH);

   logic [PTRW-1:0] w_pos;
   logic            w_match;

   // Walk from oldest (head) to youngest so a later match overrides an earlier one
   always_comb begin
      o_hit   = 1'b0;
      o_data  = {XLEN{1'b0}};
      w_pos   = {PTRW{1'b0}};
      w_match = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         w_pos   = i_head + PTRW'(k);
         w_match = (CNTW'(k) < i_count) &&
                   (i_idx != {REG_IDX_W{1'b0}}) &&
                   (i_entries[w_pos].rd == i_idx);
         o_hit   = o_hit | w_match;
         o_data  = w_match ? i_entries[w_pos].data : o_data;
      end
   end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Register-file writeback queue.
// Accepts ALU and load results through valid/ready handshakes and holds them in an
// in-order ring buffer. It retires the head entry every cycle the buffer is not empty.
// Load results take priority over ALU results because they are older in program order.
// Writes to x0 are acknowledged but never stored.
module regfile_writeback_queue
   import rv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_IDX_W-1:0]  alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_IDX_W-1:0]  mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   output logic                  RegWrite,
   output logic [REG_IDX_W-1:0]  wb_rd,
   output logic [XLEN-1:0]       WriteData,
   input  logic [REG_IDX_W-1:0]  rs1_idx,
   output logic                  rs1_hit,
   output logic [XLEN-1:0]       rs1_data,
   input  logic [REG_IDX_W-1:0]  rs2_idx,
   output logic                  rs2_hit,
   output logic [XLEN-1:0]       rs2_data,
   output logic [CNTW-1:0]       count,
   output logic                  full,
   output logic                  empty
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int FW   = CNTW + 1;

   wb_entry_t [DEPTH-1:0] r_mem;
   logic [PTRW-1:0]       r_head;
   logic [PTRW-1:0]       r_tail;
   logic [CNTW-1:0]       r_count;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic [FW-1:0]         w_free;
   logic                  w_mem_needs_slot;
   logic                  w_push_mem;
   logic                  w_push_alu;
   logic [PTRW-1:0]       w_alu_slot;
   wb_entry_t             w_head_entry;

   assign w_empty = (r_count == {CNTW{1'b0}});
   assign w_full  = (r_count == CNTW'(DEPTH));
   assign w_pop   = ~w_empty;

   // The slot being retired this cycle is available to a new push at the same edge.
   assign w_free  = FW'(DEPTH) - {1'b0, r_count} + {{CNTW{1'b0}}, w_pop};

   // A load with rd==0 is dropped, so it does not take a slot away from the ALU.
   assign w_mem_needs_slot = mem_valid & (mem_rd != {REG_IDX_W{1'b0}});
   assign mem_ready        = (w_free >= FW'(1));
   assign alu_ready        = (w_free >= (FW'(1) + {{CNTW{1'b0}}, w_mem_needs_slot}));

   assign w_push_mem = mem_valid & mem_ready & (mem_rd != {REG_IDX_W{1'b0}});
   assign w_push_alu = alu_valid & alu_ready & (alu_rd != {REG_IDX_W{1'b0}});

   // When both ports push in the same cycle, the ALU entry goes behind the load entry.
   assign w_alu_slot = r_tail + PTRW'(w_push_mem);

   // Ring-buffer state: storage, head/tail pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem   <= {($bits(r_mem)){1'b0}};
         r_head  <= {PTRW{1'b0}};
         r_tail  <= {PTRW{1'b0}};
         r_count <= {CNTW{1'b0}};
      end else begin
         if (w_push_mem) begin
            r_mem[r_tail] <= {mem_rd, mem_data};
         end
         if (w_push_alu) begin
            r_mem[w_alu_slot] <= {alu_rd, alu_data};
         end
         r_head  <= r_head + PTRW'(w_pop);
         r_tail  <= r_tail + PTRW'(w_push_mem) + PTRW'(w_push_alu);
         r_count <= r_count + CNTW'(w_push_mem) + CNTW'(w_push_alu) - CNTW'(w_pop);
      end
   end

   // The register file latches the head entry at the same edge that pops it.
   assign w_head_entry = r_mem[r_head];
   assign RegWrite     = w_pop;
   assign wb_rd        = w_pop ? w_head_entry.rd   : {REG_IDX_W{1'b0}};
   assign WriteData    = w_pop ? w_head_entry.data : {XLEN{1'b0}};

   assign count = r_count;
   assign full  = w_full;
   assign empty = w_empty;

   wb_bypass_match #(
      .DEPTH (DEPTH),
      .CNTW  (CNTW)
   ) u_bypass_rs1 (
      .i_entries (r_mem),
      .i_head    (r_head),
      .i_count   (r_count),
      .i_idx     (rs1_idx),
      .o_hit     (rs1_hit),
      .o_data    (rs1_data)
   );

   wb_bypass_match #(
      .DEPTH (DEPTH),
      .CNTW  (CNTW)
   ) u_bypass_rs2 (
      .i_entries (r_mem),
      .i_head    (r_head),
      .i_count   (r_count),
      .i_idx     (rs2_idx),
      .o_hit     (rs2_hit),
      .o_data    (rs2_data)
   );

endmodule
